// File: rtl/cdc_pkg.sv
// -----------------------------------------------------------------------------
// cdc_pkg
//
// Shared definitions for the source-side four-phase crossing controller:
//   - state_t          : handshake FSM states
//   - grant_t          : result of the round-robin priority search
//   - rr_search()      : first valid requester at or after the pointer, wrapping
//   - phase_cnt_width(): width of a counter that can hold the timeout limit
// -----------------------------------------------------------------------------
package cdc_pkg;

    // Encoding is chosen so that bit 0 is set only in REQ_HI. The crossing
    // request is taken straight from that flop, with no decode logic after it.
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        REQ_HI = 2'b01,
        REQ_LO = 2'b10
    } state_t;

    // The search always works on a 16-entry vector; narrower requester sets
    // are zero-extended and the modulus is the real requester count.
    localparam int MAX_N = 16;
    localparam int IDX_W = 4;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } grant_t;

    function automatic int phase_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

    // Searches n entries starting at rr. The loop runs from the farthest
    // offset down to offset 0, so the last hit written is the closest one.
    function automatic grant_t rr_search(input logic [MAX_N-1:0] valid,
                                         input logic [IDX_W-1:0] rr,
                                         input int               n);
        grant_t           g;
        int               pos;
        logic [IDX_W-1:0] pos_v;
        g = '0;
        for (int k = MAX_N - 1; k >= 0; k--) begin
            if (k < n) begin
                pos   = (int'(rr) + k) % n;
                pos_v = IDX_W'(pos);
                if (valid[pos_v]) begin
                    g.found = 1'b1;
                    g.idx   = pos_v;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// -----------------------------------------------------------------------------
// cdc_sync_bit
//
// A multi-flop synchronizer for one asynchronous level. Its depth is set by a
// parameter. All flops reset asynchronously to 0.
//
// Ports:
//   clock : destination (local) clock
//   reset : asynchronous, active-high reset
//   d     : asynchronous input level
//   q     : synchronized level, STAGES cycles behind d
// -----------------------------------------------------------------------------
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_handshake_arbiter.sv
// -----------------------------------------------------------------------------
// cdc_handshake_arbiter
//
// This is the source-side controller for a shared four-phase req/ack clock
// domain crossing. It arbitrates round-robin among N local requesters. It
// copies the winner's payload into a hold register and then drives the
// handshake: raise x_req, wait for ack high, drop x_req, wait for ack low.
//
// Local request handshake: requester i offers a word by holding req_valid[i].
// The word is taken in the cycle where req_valid[i] and req_ready[i] are both
// high. req_ready is one-hot, can only be high in IDLE, and is combinational
// from req_valid. The requester may drop or change its request after that
// cycle.
//
// Ports:
//   clock, reset    : source clock, asynchronous active-high reset
//   req_valid [N]   : per-requester request
//   req_data [N*W]  : payloads, requester i at [i*W +: W]
//   req_ready [N]   : one-hot acceptance strobe
//   x_req           : crossing request (four-phase)
//   x_data [W]      : held payload, stable from accept until the next accept
//   x_src           : id of the requester being served
//   x_ack           : raw acknowledge from the destination (asynchronous)
//   done, done_src  : one-cycle completion pulse and the completed id
//   busy            : high outside IDLE
//   timeout_err     : sticky phase-timeout flag
//   err_clear       : clears timeout_err (a same-cycle set wins)
// -----------------------------------------------------------------------------
module cdc_handshake_arbiter
    import cdc_pkg::*;
#(
    parameter int N           = 4,
    parameter int W           = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    input  logic [N*W-1:0]       req_data,
    output logic [N-1:0]         req_ready,
    output logic                 x_req,
    output logic [W-1:0]         x_data,
    output logic [$clog2(N)-1:0] x_src,
    input  logic                 x_ack,
    output logic                 done,
    output logic [$clog2(N)-1:0] done_src,
    output logic                 busy,
    output logic                 timeout_err,
    input  logic                 err_clear
);

    localparam int SW = $clog2(N);
    localparam int CW = phase_cnt_width(TIMEOUT);

    state_t          state;
    state_t          state_next;
    logic            ack_s;
    grant_t          grant;
    logic [SW-1:0]   grant_idx;
    logic            accept;
    logic [SW-1:0]   rr;
    logic [CW-1:0]   phase_cnt;
    logic            phase_change;
    logic            timeout_hit;
    logic            unused_grant_bits;

    // ------------------------------------------------------------------
    // Acknowledge synchronizer
    // ------------------------------------------------------------------
    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clock (clock),
        .reset (reset),
        .d     (x_ack),
        .q     (ack_s)
    );

    // ------------------------------------------------------------------
    // Round-robin grant (combinational)
    // ------------------------------------------------------------------
    always_comb begin
        grant     = rr_search(MAX_N'(req_valid), IDX_W'(rr), N);
        grant_idx = grant.idx[SW-1:0];
    end

    // If N < 16, the upper index bits are always zero.
    assign unused_grant_bits = ^grant.idx;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (grant.found) begin
                    accept     = 1'b1;
                    state_next = REQ_HI;
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    state_next = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // x_req comes straight from the state flop, with no gating after it.
    assign x_req = state[0];
    assign busy  = (state != IDLE);

    // ------------------------------------------------------------------
    // Hold register, requester id, round-robin pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x_data <= '0;
            x_src  <= '0;
            rr     <= '0;
        end else if (accept) begin
            x_data <= req_data[int'(grant_idx)*W +: W];
            x_src  <= grant_idx;
            rr     <= (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Completion pulse: falls out of the REQ_LO -> IDLE transition
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done     <= 1'b0;
            done_src <= '0;
        end else begin
            done <= (state == REQ_LO) && !ack_s;
            if ((state == REQ_LO) && !ack_s) begin
                done_src <= x_src;
            end
        end
    end

    // ------------------------------------------------------------------
    // Phase counter and sticky timeout flag
    // ------------------------------------------------------------------
    assign phase_change = (state_next != state);

    // The flag is raised only on the step that brings the counter up to
    // TIMEOUT. While the counter sits saturated it does not raise the flag
    // again, so a cleared flag stays clear until a later phase times out.
    assign timeout_hit = (state != IDLE) && !phase_change &&
                         (phase_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase_cnt <= '0;
        end else if (phase_change) begin
            phase_cnt <= '0;
        end else if ((state != IDLE) && (phase_cnt != CW'(TIMEOUT))) begin
            phase_cnt <= phase_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end else if (err_clear) begin
            timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdc_handshake_arbiter.sv
module tb_cdc_handshake_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SS = 2;
    localparam int TO = 16;
    localparam int SW = $clog2(N);

    // ---------------- clock / reset ----------------
    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           x_req;
    logic [W-1:0]   x_data;
    logic [SW-1:0]  x_src;
    logic           x_ack = 1'b0;
    logic           done;
    logic [SW-1:0]  done_src;
    logic           busy;
    logic           timeout_err;
    logic           err_clear;

    always #5 clock = ~clock;

    cdc_handshake_arbiter #(
        .N           (N),
        .W           (W),
        .SYNC_STAGES (SS),
        .TIMEOUT     (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .x_req       (x_req),
        .x_data      (x_data),
        .x_src       (x_src),
        .x_ack       (x_ack),
        .done        (done),
        .done_src    (done_src),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clear   (err_clear)
    );

    // ---------------- counters / scoreboard ----------------
    int tests    = 0;
    int fails    = 0;
    int done_cnt = 0;
    logic [SW+W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- destination responder ----------------
    // With ack_enable set, x_ack follows x_req ack_delay cycles later.
    // Without it, x_ack takes the level held in ack_force.
    bit ack_enable = 1'b0;
    bit ack_force  = 1'b0;
    int ack_delay  = 0;
    int ack_wait   = 0;

    always begin
        @(posedge clock);
        #1;
        if (reset) begin
            x_ack    = 1'b0;
            ack_wait = 0;
        end else if (!ack_enable) begin
            x_ack = ack_force;
        end else if (x_ack != x_req) begin
            if (ack_wait >= ack_delay) begin
                x_ack    = x_req;
                ack_wait = 0;
            end else begin
                ack_wait++;
            end
        end else begin
            ack_wait = 0;
        end
    end

    // ---------------- completion monitor ----------------
    always @(negedge clock) begin
        if (!reset && done) begin
            logic [SW+W-1:0] e;
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("done_unexpected", 64'(done), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check("done_src", 64'(done_src), 64'(e[SW+W-1:W]));
                check("done_data", 64'(x_data), 64'(e[W-1:0]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clock);
        reset      = 1'b1;
        ack_enable = 1'b0;
        ack_force  = 1'b0;
        req_valid  = '0;
        err_clear  = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1'b1;
        end
        check(tag, 64'(seen), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_x_req"},    64'(x_req),       64'(0));
        check({tag, "_x_data"},   64'(x_data),      64'(0));
        check({tag, "_x_src"},    64'(x_src),       64'(0));
        check({tag, "_done"},     64'(done),        64'(0));
        check({tag, "_done_src"}, 64'(done_src),    64'(0));
        check({tag, "_busy"},     64'(busy),        64'(0));
        check({tag, "_tmo"},      64'(timeout_err), 64'(0));
        check({tag, "_ready"},    64'(req_ready),   64'(0));
    endtask

    // ---------------- directed sequence ----------------
    logic [W-1:0] pay [N];
    int acc_at [8];
    int n_acc;
    int base;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        err_clear = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("rst");
        reset = 1'b0;

        // ---- single transfer, ack 3 cycles after x_req ----
        @(negedge clock);
        ack_enable = 1'b1;
        ack_delay  = 3;
        req_data[2*W +: W] = 32'hDEADBEEF;
        req_valid = 4'b0100;
        exp_q.push_back({2'd2, 32'hDEADBEEF});
        #1 check("t1_ready", 64'(req_ready), 64'(4'b0100));
        @(negedge clock);
        check("t1_ready_in_hi", 64'(req_ready), 64'(0));
        req_valid = '0;
        check("t1_x_req", 64'(x_req), 64'(1));
        check("t1_busy", 64'(busy), 64'(1));
        check("t1_x_src", 64'(x_src), 64'(2));
        check("t1_x_data", 64'(x_data), 64'(32'hDEADBEEF));
        wait_done(40, "t1_done");
        @(negedge clock);
        check("t1_done_pulse", 64'(done), 64'(0));
        check("t1_idle", 64'(busy), 64'(0));

        // ---- fairness and back-to-back spacing with immediate ack ----
        do_reset();
        ack_enable = 1'b1;
        ack_delay  = 0;
        for (int i = 0; i < N; i++) begin
            pay[i] = $urandom;
            req_data[i*W +: W] = pay[i];
        end
        for (int k = 0; k < 8; k++) exp_q.push_back({2'(k % N), pay[k % N]});
        base  = done_cnt;
        n_acc = 0;
        req_valid = 4'hF;
        for (int c = 0; c < 200 && n_acc < 8; c++) begin
            #1;
            if (req_ready != 0) begin
                acc_at[n_acc] = c;
                n_acc++;
                if (n_acc == 8) begin
                    @(posedge clock);
                    #1 req_valid = '0;
                end
            end
            @(negedge clock);
        end
        check("t2_accepts", 64'(n_acc), 64'(8));
        for (int k = 1; k < 8; k++)
            check("t2_spacing", 64'(acc_at[k] - acc_at[k-1]), 64'(2*SS+3));
        for (int c = 0; c < 50 && done_cnt < base + 8; c++) @(negedge clock);
        check("t2_dones", 64'(done_cnt - base), 64'(8));
        check("t2_q_empty", 64'(exp_q.size()), 64'(0));

        // ---- timeout with ack held low, payload isolation ----
        do_reset();
        ack_enable = 1'b0;
        ack_force  = 1'b0;
        req_data[0 +: W] = 32'h12345678;
        req_valid = 4'b0001;
        exp_q.push_back({2'd0, 32'h12345678});
        for (int k = 1; k <= TO + 1; k++) begin
            @(negedge clock);
            if (k == 1) req_valid = '0;
            if (k == 2) req_data[0 +: W] = 32'hCAFEF00D;
            if (k == TO) check("t3_tmo_early", 64'(timeout_err), 64'(0));
        end
        check("t3_tmo_set", 64'(timeout_err), 64'(1));
        check("t3_x_req_held", 64'(x_req), 64'(1));
        check("t3_x_data_held", 64'(x_data), 64'(32'h12345678));
        err_clear = 1'b1;
        @(negedge clock);
        err_clear = 1'b0;
        check("t3_tmo_cleared", 64'(timeout_err), 64'(0));
        repeat (20) @(negedge clock);
        check("t3_tmo_stays_clear", 64'(timeout_err), 64'(0));
        check("t3_x_req_still", 64'(x_req), 64'(1));
        check("t3_x_data_still", 64'(x_data), 64'(32'h12345678));
        ack_enable = 1'b1;
        ack_delay  = 0;
        wait_done(30, "t3_done");
        req_valid = 4'b0001;
        exp_q.push_back({2'd0, 32'hCAFEF00D});
        @(negedge clock);
        req_valid = '0;
        check("t3_next_payload", 64'(x_data), 64'(32'hCAFEF00D));
        wait_done(30, "t3_done2");

        // ---- timeout set wins over a simultaneous clear ----
        ack_enable = 1'b0;
        ack_force  = 1'b0;
        req_data[0 +: W] = 32'h0BADC0DE;
        req_valid = 4'b0001;
        exp_q.push_back({2'd0, 32'h0BADC0DE});
        err_clear = 1'b1;
        for (int k = 1; k <= TO + 1; k++) begin
            @(negedge clock);
            if (k == 1) req_valid = '0;
        end
        check("t4_set_wins", 64'(timeout_err), 64'(1));
        @(negedge clock);
        check("t4_clear_after", 64'(timeout_err), 64'(0));
        err_clear = 1'b0;

        // ---- reset asserted while waiting in REQ_LO ----
        ack_force = 1'b1;
        repeat (5) @(negedge clock);
        check("t5_in_lo_x_req", 64'(x_req), 64'(0));
        check("t5_in_lo_busy", 64'(busy), 64'(1));
        #2 reset = 1'b1;
        #1 check_reset_outputs("t5_async");
        exp_q.delete();
        ack_force = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        req_data[0 +: W]   = 32'h11111111;
        req_data[3*W +: W] = 32'h33333333;
        req_valid = 4'b1001;
        #1 check("t5_first_grant", 64'(req_ready), 64'(4'b0001));
        exp_q.push_back({2'd0, 32'h11111111});
        @(negedge clock);
        req_valid  = '0;
        ack_enable = 1'b1;
        ack_delay  = 1;
        wait_done(40, "t5_done");
        req_valid = 4'b1001;
        #1 check("t5_rr_next", 64'(req_ready), 64'(4'b1000));
        exp_q.push_back({2'd3, 32'h33333333});
        @(negedge clock);
        req_valid = '0;
        wait_done(40, "t5_done2");

        @(negedge clock);
        check("final_q_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
